// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bus between the MEM stage (master) and the
// responder (slave). Optional macro: DMEM_BYTE_WRITE_EN adds the req_be lanes.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]  req_be;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Pipeline side: issues requests, consumes responses.
  modport master (
`ifdef DMEM_BYTE_WRITE_EN
    output req_be,
`endif
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Memory side: accepts requests, produces responses.
  modport slave (
`ifdef DMEM_BYTE_WRITE_EN
    input  req_be,
`endif
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: one outstanding load/store, serviced from
// an internal word array; the response becomes valid LATENCY edges after
// the request is accepted and is held until the pipeline takes it.
// Optional macro: DMEM_BYTE_WRITE_EN (per-byte store lanes via req_be).
module data_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic                 stall
);

  // Counter holds at most LATENCY-1.
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;

  logic              accept;
  logic              do_access;
  logic              rsp_fire;

  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  logic              lat_write;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]        lat_be;
`endif

  logic              access_err;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       wr_word;

  logic [31:0]       mem [DEPTH];

  // State and latency counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; the access fires on the edge that leaves BUSY.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    do_access  = 1'b0;
    rsp_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          accept     = 1'b1;
          state_next = BUSY;
          cnt_next   = CNT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          do_access  = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_valid && bus.rsp_ready) begin
          rsp_fire   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address decode of the latched request; out-of-range never aliases.
  always_comb begin
    idx        = lat_addr[ADDR_W+1:2];
    access_err = (lat_addr[1:0] != 2'b00) || (lat_addr[31:2] >= 30'(DEPTH));
  end

  // Store word, merged with the current contents when byte lanes are enabled.
  always_comb begin
    wr_word = lat_wdata;
`ifdef DMEM_BYTE_WRITE_EN
    for (int b = 0; b < 4; b++) begin
      wr_word[8*b +: 8] = lat_be[b] ? lat_wdata[8*b +: 8] : mem[idx][8*b +: 8];
    end
`endif
  end

  // Handshake/status outputs follow the registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      stall         <= 1'b0;
    end else begin
      bus.req_ready <= (state_next == IDLE);
      bus.rsp_valid <= (state_next == RESP);
      stall         <= (state_next != IDLE);
    end
  end

  // Request capture, array access and response payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr      <= '0;
      lat_wdata     <= '0;
      lat_write     <= 1'b0;
`ifdef DMEM_BYTE_WRITE_EN
      lat_be        <= '0;
`endif
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (accept) begin
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        lat_write <= bus.req_write;
`ifdef DMEM_BYTE_WRITE_EN
        lat_be    <= bus.req_be;
`endif
      end
      if (do_access) begin
        bus.rsp_err <= access_err;
        if (access_err || lat_write) begin
          bus.rsp_rdata <= '0;
        end else begin
          bus.rsp_rdata <= mem[idx];
        end
        if (lat_write && !access_err) begin
          mem[idx] <= wr_word;
        end
      end else if (rsp_fire) begin
        bus.rsp_rdata <= '0;
        bus.rsp_err   <= 1'b0;
      end
    end
  end

endmodule
